vio_switch_n: RTL and testbench



---
 rtl/vio_switch_n_pkg.sv | 21 ++
 rtl/vio_switch_n_rr_arb.sv | 69 ++++++
 rtl/vio_switch_n.sv | 266 ++++++++++++++++++++++++++
 tb/tb_vio_switch_n.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vio_switch_n_pkg.sv
// Shared types for the vio_switch_n crossbar: destination field width,
// per-slave state encoding and the host destination builder.
package vio_switch_n_pkg;

    localparam int VIO_DEST_BITS = 4;

    typedef logic [VIO_DEST_BITS-1:0] vio_dest_t;

    typedef enum logic [1:0] {
        VIO_IDLE = 2'd0,
        VIO_REQ  = 2'd1,
        VIO_XFER = 2'd2,
        VIO_DROP = 2'd3
    } vio_slave_state_e;

    // Host sink i always targets DTU master n_id+i; the remaining route bits are all ones.
    function automatic vio_dest_t vio_host_dest(input int host_idx, input int n_id);
        return vio_dest_t'(n_id + host_idx);
    endfunction

endpackage

// File: rtl/vio_switch_n_rr_arb.sv
// Packet-locked round-robin arbiter. The grant is combinational while idle
// and is held on the winner until unlock (tlast accepted) is seen.
module vio_rr_arb #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         unlock,
    output logic [N-1:0] grant
);
    localparam int IW = $clog2(N);

    logic          busy_q, busy_d;
    logic [N-1:0]  owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  pick;
    logic [IW-1:0] pick_idx;
    int            idx;

    // Lowest requester at or above the pointer, wrapping.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        idx      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % N;
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
                pick_idx  = IW'(idx);
            end
        end
    end

    // Locked owner wins over any fresh pick.
    always_comb begin
        grant = busy_q ? owner_q : pick;
    end

    // Lock on a fresh grant, release on unlock (same cycle for single-beat packets).
    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (!busy_q && (|pick)) begin
            busy_d  = 1'b1;
            owner_d = pick;
            ptr_d   = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
        end
        if (unlock) begin
            busy_d = 1'b0;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: rtl/vio_switch_n.sv
// Crossbar between N_ID host streams and N_ID DTU streams. Slaves 0..N_ID-1
// are host sinks, N_ID..2*N_ID-1 are DTU sinks; masters use the same split.
//
// slave state | meaning
// IDLE        | waiting for a head beat, route sampled here
// REQ         | legal head held, requesting the target master
// XFER        | granted, streaming until tlast handshake
// DROP        | illegal dest, sinking beats until tlast handshake
module vio_switch_n
    import vio_switch_n_pkg::*;
#(
    parameter int N_ID       = 4,
    parameter int DATA_BITS  = 32,
    parameter int ID_BITS    = 4,
    parameter int ROUTE_BITS = 14
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic [N_ID-1:0][ROUTE_BITS-1:0]      route_in,
    output logic [N_ID-1:0][ROUTE_BITS-1:0]      route_out,
    input  logic [N_ID-1:0]                      data_host_sink_tvalid,
    output logic [N_ID-1:0]                      data_host_sink_tready,
    input  logic [N_ID-1:0][DATA_BITS-1:0]       data_host_sink_tdata,
    input  logic [N_ID-1:0][DATA_BITS/8-1:0]     data_host_sink_tkeep,
    input  logic [N_ID-1:0]                      data_host_sink_tlast,
    output logic [N_ID-1:0]                      data_host_src_tvalid,
    input  logic [N_ID-1:0]                      data_host_src_tready,
    output logic [N_ID-1:0][DATA_BITS-1:0]       data_host_src_tdata,
    output logic [N_ID-1:0][DATA_BITS/8-1:0]     data_host_src_tkeep,
    output logic [N_ID-1:0]                      data_host_src_tlast,
    output logic [N_ID-1:0][ID_BITS-1:0]         data_host_src_tid,
    input  logic [N_ID-1:0]                      data_dtu_sink_tvalid,
    output logic [N_ID-1:0]                      data_dtu_sink_tready,
    input  logic [N_ID-1:0][DATA_BITS-1:0]       data_dtu_sink_tdata,
    input  logic [N_ID-1:0][DATA_BITS/8-1:0]     data_dtu_sink_tkeep,
    input  logic [N_ID-1:0]                      data_dtu_sink_tlast,
    input  logic [N_ID-1:0][ID_BITS-1:0]         data_dtu_sink_tid,
    output logic [N_ID-1:0]                      data_dtu_src_tvalid,
    input  logic [N_ID-1:0]                      data_dtu_src_tready,
    output logic [N_ID-1:0][DATA_BITS-1:0]       data_dtu_src_tdata,
    output logic [N_ID-1:0][DATA_BITS/8-1:0]     data_dtu_src_tkeep,
    output logic [N_ID-1:0]                      data_dtu_src_tlast,
    output logic [N_ID-1:0][ID_BITS-1:0]         data_dtu_src_tid,
    output logic [2*N_ID-1:0]                    s_decode_err,
    output logic [31:0]                          decode_err_cnt
);
    localparam int NS       = 2 * N_ID;
    localparam int KW       = DATA_BITS / 8;
    localparam int BW       = ID_BITS + 1 + KW + DATA_BITS;
    localparam int LOW_BITS = ROUTE_BITS - VIO_DEST_BITS;

    // Beat layout: {tid, tlast, tkeep, tdata}
    logic [NS-1:0]                 s_valid, s_ready, s_last, s_hs, s_gnt;
    logic [NS-1:0][BW-1:0]         s_beat;
    logic [NS-1:0][ROUTE_BITS-1:0] s_route;

    vio_slave_state_e              state_q [NS];
    vio_slave_state_e              state_d [NS];
    logic [NS-1:0][ROUTE_BITS-1:0] route_q, route_d;
    logic [NS-1:0]                 err_q, err_d;
    logic [31:0]                   cnt_q, cnt_d;
    logic [32:0]                   cnt_sum;

    logic [NS-1:0][NS-1:0]         req, grant;
    logic [NS-1:0]                 m_push, m_pop, m_full, m_valid, m_ready, m_last_in;
    logic [NS-1:0][BW-1:0]         m_beat_in;
    logic [NS-1:0][1:0]            fcnt_q, fcnt_d;
    logic [NS-1:0][BW-1:0]         b0_q, b0_d, b1_q, b1_d;
    logic [N_ID-1:0][ROUTE_BITS-1:0] route_out_q, route_out_d;

    for (genvar i = 0; i < N_ID; i++) begin : g_port
        assign s_valid[i]      = data_host_sink_tvalid[i];
        assign s_last[i]       = data_host_sink_tlast[i];
        assign s_beat[i]       = {{ID_BITS{1'b0}}, data_host_sink_tlast[i],
                                  data_host_sink_tkeep[i], data_host_sink_tdata[i]};
        assign s_route[i]      = {vio_host_dest(i, N_ID), {LOW_BITS{1'b1}}};
        assign data_host_sink_tready[i] = s_ready[i];

        assign s_valid[N_ID+i] = data_dtu_sink_tvalid[i];
        assign s_last[N_ID+i]  = data_dtu_sink_tlast[i];
        assign s_beat[N_ID+i]  = {data_dtu_sink_tid[i], data_dtu_sink_tlast[i],
                                  data_dtu_sink_tkeep[i], data_dtu_sink_tdata[i]};
        assign s_route[N_ID+i] = route_in[i];
        assign data_dtu_sink_tready[i] = s_ready[N_ID+i];

        assign data_host_src_tvalid[i] = m_valid[i];
        assign m_ready[i]              = data_host_src_tready[i];
        assign {data_host_src_tid[i], data_host_src_tlast[i],
                data_host_src_tkeep[i], data_host_src_tdata[i]} = b0_q[i];

        assign data_dtu_src_tvalid[i]  = m_valid[N_ID+i];
        assign m_ready[N_ID+i]         = data_dtu_src_tready[i];
        assign {data_dtu_src_tid[i], data_dtu_src_tlast[i],
                data_dtu_src_tkeep[i], data_dtu_src_tdata[i]} = b0_q[N_ID+i];
    end

    for (genvar m = 0; m < NS; m++) begin : g_arb
        vio_rr_arb #(.N(NS)) u_arb (
            .clk    (aclk),
            .rst_n  (aresetn),
            .req    (req[m]),
            .unlock (m_push[m] & m_last_in[m]),
            .grant  (grant[m])
        );
    end

    assign s_hs           = s_valid & s_ready;
    assign route_out      = route_out_q;
    assign s_decode_err   = err_q;
    assign decode_err_cnt = cnt_q;

    // Slaves in REQ raise a request on the master named by their held route.
    always_comb begin
        req = '0;
        for (int s = 0; s < NS; s++) begin
            for (int m = 0; m < NS; m++) begin
                if (int'(route_q[s][ROUTE_BITS-1 -: VIO_DEST_BITS]) == m) begin
                    req[m][s] = (state_q[s] == VIO_REQ);
                end
            end
        end
    end

    // Slave ready: granted slaves see their master's skid not-full, dropping slaves always ready.
    always_comb begin
        s_ready = '0;
        s_gnt   = '0;
        for (int s = 0; s < NS; s++) begin
            for (int m = 0; m < NS; m++) begin
                if (int'(route_q[s][ROUTE_BITS-1 -: VIO_DEST_BITS]) == m) begin
                    s_gnt[s] = grant[m][s];
                    if (state_q[s] == VIO_REQ || state_q[s] == VIO_XFER) begin
                        s_ready[s] = grant[m][s] & ~m_full[m];
                    end
                end
            end
            if (state_q[s] == VIO_DROP) begin
                s_ready[s] = 1'b1;
            end
        end
    end

    // Per-slave state machine; the route is captured only while IDLE.
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            state_d[s] = state_q[s];
        end
        route_d = route_q;
        err_d   = '0;
        for (int s = 0; s < NS; s++) begin
            case (state_q[s])
                VIO_IDLE: begin
                    if (s_valid[s]) begin
                        route_d[s] = s_route[s];
                        if (int'(s_route[s][ROUTE_BITS-1 -: VIO_DEST_BITS]) >= NS) begin
                            state_d[s] = VIO_DROP;
                            err_d[s]   = 1'b1;
                        end else begin
                            state_d[s] = VIO_REQ;
                        end
                    end
                end
                VIO_REQ: begin
                    if (s_gnt[s]) begin
                        state_d[s] = (s_hs[s] && s_last[s]) ? VIO_IDLE : VIO_XFER;
                    end
                end
                VIO_XFER, VIO_DROP: begin
                    if (s_hs[s] && s_last[s]) begin
                        state_d[s] = VIO_IDLE;
                    end
                end
                default: state_d[s] = VIO_IDLE;
            endcase
        end
    end

    // Saturating drop counter.
    always_comb begin
        cnt_sum = {1'b0, cnt_q} + 33'($countones(err_d));
        cnt_d   = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end

    // One-hot grant selects the beat that enters each master's skid.
    always_comb begin
        m_push    = '0;
        m_beat_in = '0;
        m_last_in = '0;
        for (int m = 0; m < NS; m++) begin
            for (int s = 0; s < NS; s++) begin
                if (grant[m][s]) begin
                    m_push[m]    = s_hs[s];
                    m_beat_in[m] = s_beat[s];
                    m_last_in[m] = s_last[s];
                end
            end
        end
    end

    // Skid occupancy flags.
    always_comb begin
        for (int m = 0; m < NS; m++) begin
            m_valid[m] = (fcnt_q[m] != 2'd0);
            m_full[m]  = (fcnt_q[m] == 2'd2);
            m_pop[m]   = m_valid[m] & m_ready[m];
        end
    end

    // Two-entry skid: b0 is the presented beat, b1 holds the one in flight behind it.
    always_comb begin
        fcnt_d = fcnt_q;
        b0_d   = b0_q;
        b1_d   = b1_q;
        for (int m = 0; m < NS; m++) begin
            case ({m_push[m], m_pop[m]})
                2'b10: begin
                    if (fcnt_q[m] == 2'd0) b0_d[m] = m_beat_in[m];
                    else                   b1_d[m] = m_beat_in[m];
                    fcnt_d[m] = fcnt_q[m] + 2'd1;
                end
                2'b01: begin
                    b0_d[m]   = b1_q[m];
                    fcnt_d[m] = fcnt_q[m] - 2'd1;
                end
                2'b11: b0_d[m] = (fcnt_q[m] == 2'd1) ? m_beat_in[m] : b1_q[m];
                default: ;
            endcase
        end
    end

    // DTU masters latch the winner's route on the grant cycle.
    always_comb begin
        route_out_d = route_out_q;
        for (int j = 0; j < N_ID; j++) begin
            for (int s = 0; s < NS; s++) begin
                if (grant[N_ID+j][s] && state_q[s] == VIO_REQ) begin
                    route_out_d[j] = route_q[s];
                end
            end
        end
    end

    // State registers; reset abandons any partial packet.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= '{default: VIO_IDLE};
            route_q     <= '0;
            err_q       <= '0;
            cnt_q       <= '0;
            fcnt_q      <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            route_out_q <= '0;
        end else begin
            state_q     <= state_d;
            route_q     <= route_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            fcnt_q      <= fcnt_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            route_out_q <= route_out_d;
        end
    end

endmodule

// File: tb/tb_vio_switch_n.sv
// Directed bench for vio_switch_n with N_ID=4. Slave/master index s: 0..3 host, 4..7 DTU.
module tb_vio_switch_n;
    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int IDW = 4;
    localparam int RW  = 14;
    localparam int KW  = DW / 8;

    logic aclk = 1'b0;
    logic aresetn;
    logic [N-1:0][RW-1:0]  route_in, route_out;
    logic [N-1:0]          hs_tvalid, hs_tready, hs_tlast;
    logic [N-1:0][DW-1:0]  hs_tdata;
    logic [N-1:0][KW-1:0]  hs_tkeep;
    logic [N-1:0]          hm_tvalid, hm_tready, hm_tlast;
    logic [N-1:0][DW-1:0]  hm_tdata;
    logic [N-1:0][KW-1:0]  hm_tkeep;
    logic [N-1:0][IDW-1:0] hm_tid;
    logic [N-1:0]          ds_tvalid, ds_tready, ds_tlast;
    logic [N-1:0][DW-1:0]  ds_tdata;
    logic [N-1:0][KW-1:0]  ds_tkeep;
    logic [N-1:0][IDW-1:0] ds_tid;
    logic [N-1:0]          dm_tvalid, dm_tready, dm_tlast;
    logic [N-1:0][DW-1:0]  dm_tdata;
    logic [N-1:0][KW-1:0]  dm_tkeep;
    logic [N-1:0][IDW-1:0] dm_tid;
    logic [2*N-1:0]        s_decode_err;
    logic [31:0]           decode_err_cnt;

    vio_switch_n #(.N_ID(N), .DATA_BITS(DW), .ID_BITS(IDW), .ROUTE_BITS(RW)) dut (
        .aclk(aclk), .aresetn(aresetn), .route_in(route_in), .route_out(route_out),
        .data_host_sink_tvalid(hs_tvalid), .data_host_sink_tready(hs_tready),
        .data_host_sink_tdata(hs_tdata), .data_host_sink_tkeep(hs_tkeep),
        .data_host_sink_tlast(hs_tlast),
        .data_host_src_tvalid(hm_tvalid), .data_host_src_tready(hm_tready),
        .data_host_src_tdata(hm_tdata), .data_host_src_tkeep(hm_tkeep),
        .data_host_src_tlast(hm_tlast), .data_host_src_tid(hm_tid),
        .data_dtu_sink_tvalid(ds_tvalid), .data_dtu_sink_tready(ds_tready),
        .data_dtu_sink_tdata(ds_tdata), .data_dtu_sink_tkeep(ds_tkeep),
        .data_dtu_sink_tlast(ds_tlast), .data_dtu_sink_tid(ds_tid),
        .data_dtu_src_tvalid(dm_tvalid), .data_dtu_src_tready(dm_tready),
        .data_dtu_src_tdata(dm_tdata), .data_dtu_src_tkeep(dm_tkeep),
        .data_dtu_src_tlast(dm_tlast), .data_dtu_src_tid(dm_tid),
        .s_decode_err(s_decode_err), .decode_err_cnt(decode_err_cnt)
    );

    initial forever #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    int          tx_len [8];
    int          tx_pos [8];
    logic [31:0] tx_base [8];
    logic [13:0] tx_route [8];
    bit          tog [8];

    logic [31:0] rx_data [8][64];
    logic        rx_last [8][64];
    logic [3:0]  rx_id   [8][64];
    int          rx_cyc  [8][64];
    int          rx_n    [8];
    int          err_seen [8];
    int          valid_seen;
    int          sum;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int cyc);
        for (int i = 0; i < N; i++) begin
            hs_tvalid[i] = tx_pos[i] < tx_len[i];
            hs_tdata[i]  = tx_base[i] + 32'(tx_pos[i]);
            hs_tlast[i]  = tx_pos[i] == tx_len[i] - 1;
            hs_tkeep[i]  = '1;
            ds_tvalid[i] = tx_pos[i+N] < tx_len[i+N];
            ds_tdata[i]  = tx_base[i+N] + 32'(tx_pos[i+N]);
            ds_tlast[i]  = tx_pos[i+N] == tx_len[i+N] - 1;
            ds_tkeep[i]  = '1;
            ds_tid[i]    = 4'(i + N + 1);
            route_in[i]  = tx_route[i+N];
            hm_tready[i] = tog[i]   ? (cyc % 2 == 0) : 1'b1;
            dm_tready[i] = tog[i+N] ? (cyc % 2 == 0) : 1'b1;
        end
    endtask

    task automatic capture(input int m, input logic [31:0] d, input logic l,
                           input logic [3:0] id, input int c);
        if (rx_n[m] < 64) begin
            rx_data[m][rx_n[m]] = d;
            rx_last[m][rx_n[m]] = l;
            rx_id[m][rx_n[m]]   = id;
            rx_cyc[m][rx_n[m]]  = c;
            rx_n[m]++;
        end
    endtask

    // Called just after a rising edge: drive, sample at the falling edge, advance on handshakes.
    task automatic run(input int budget, input bit must_finish);
        bit done;
        bit hsk [8];
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            drive(c);
            @(negedge aclk);
            for (int i = 0; i < N; i++) begin
                hsk[i]   = hs_tvalid[i] && hs_tready[i];
                hsk[i+N] = ds_tvalid[i] && ds_tready[i];
                if (hm_tvalid[i]) valid_seen++;
                if (dm_tvalid[i]) valid_seen++;
                if (hm_tvalid[i] && hm_tready[i]) capture(i, hm_tdata[i], hm_tlast[i], hm_tid[i], c);
                if (dm_tvalid[i] && dm_tready[i]) capture(i + N, dm_tdata[i], dm_tlast[i], dm_tid[i], c);
            end
            for (int s = 0; s < 2 * N; s++) err_seen[s] += int'(s_decode_err[s]);
            @(posedge aclk);
            #1;
            for (int s = 0; s < 2 * N; s++) if (hsk[s]) tx_pos[s]++;
            done = 1'b1;
            for (int s = 0; s < 2 * N; s++) if (tx_pos[s] < tx_len[s]) done = 1'b0;
            if (hm_tvalid != '0 || dm_tvalid != '0) done = 1'b0;
        end
        drive(0);
        if (must_finish) chk("run_done", {63'd0, done}, 64'd1);
    endtask

    initial begin
        aresetn = 1'b0;
        for (int s = 0; s < 8; s++) begin
            tx_len[s] = 0; tx_pos[s] = 0; tx_base[s] = '0; tx_route[s] = '0;
            tog[s] = 1'b0; rx_n[s] = 0; err_seen[s] = 0;
        end
        valid_seen = 0;
        drive(0);
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_host_src_tvalid", 64'(hm_tvalid), 64'd0);
        chk("rst_dtu_src_tvalid",  64'(dm_tvalid), 64'd0);
        chk("rst_host_sink_tready", 64'(hs_tready), 64'd0);
        chk("rst_dtu_sink_tready",  64'(ds_tready), 64'd0);
        chk("rst_route_out", 64'(route_out), 64'd0);
        chk("rst_decode_err", 64'(s_decode_err), 64'd0);
        chk("rst_err_cnt", 64'(decode_err_cnt), 64'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Host sink 2 -> DTU src 2 (master 6), 3 beats
        tx_len[2] = 3; tx_pos[2] = 0; tx_base[2] = 32'hA000;
        run(40, 1'b1);
        chk("t1_count", 64'(rx_n[6]), 64'd3);
        for (int b = 0; b < 3; b++) begin
            chk("t1_data", 64'(rx_data[6][b]), 64'(32'hA000 + b));
            chk("t1_last", 64'(rx_last[6][b]), 64'(b == 2));
            chk("t1_tid",  64'(rx_id[6][b]), 64'd0);
        end
        chk("t1_latency", 64'(rx_cyc[6][0]), 64'd2);
        chk("t1_route_out2", 64'(route_out[2]), 64'h1BFF);

        // DTU sink 0 (slave 4) dest=1 -> host src 1, 4 beats
        tx_len[4] = 4; tx_pos[4] = 0; tx_base[4] = 32'hB000; tx_route[4] = 14'h0455;
        run(40, 1'b1);
        chk("t2_count", 64'(rx_n[1]), 64'd4);
        for (int b = 0; b < 4; b++) begin
            chk("t2_data", 64'(rx_data[1][b]), 64'(32'hB000 + b));
            chk("t2_last", 64'(rx_last[1][b]), 64'(b == 3));
            chk("t2_tid",  64'(rx_id[1][b]), 64'd5);
        end
        chk("t2_route_out", 64'(route_out), {8'd0, 14'h0000, 14'h1BFF, 14'h0000, 14'h0000});

        // DTU sinks 1 and 3 (slaves 5, 7) both to DTU src 0 (master 4), same cycle
        tx_len[5] = 3; tx_pos[5] = 0; tx_base[5] = 32'hC100; tx_route[5] = 14'h1011;
        tx_len[7] = 3; tx_pos[7] = 0; tx_base[7] = 32'hC300; tx_route[7] = 14'h1022;
        run(60, 1'b1);
        chk("t3_count", 64'(rx_n[4]), 64'd6);
        for (int b = 0; b < 6; b++) begin
            chk("t3_order", 64'(rx_data[4][b]),
                64'((b < 3) ? (32'hC100 + b) : (32'hC300 + b - 3)));
        end
        chk("t3_last_first_pkt", 64'(rx_last[4][2]), 64'd1);
        chk("t3_route_out0", 64'(route_out[0]), 64'h1022);

        // DTU sink 2 (slave 6) dest=9: dropped
        valid_seen = 0;
        tx_len[6] = 5; tx_pos[6] = 0; tx_base[6] = 32'hD900; tx_route[6] = 14'h24AB;
        run(40, 1'b1);
        chk("t4_accepted", 64'(tx_pos[6]), 64'd5);
        chk("t4_err_pulse6", 64'(err_seen[6]), 64'd1);
        sum = 0;
        for (int s = 0; s < 8; s++) if (s != 6) sum += err_seen[s];
        chk("t4_err_other", 64'(sum), 64'd0);
        chk("t4_err_cnt", 64'(decode_err_cnt), 64'd1);
        chk("t4_no_valid", 64'(valid_seen), 64'd0);

        // DTU sink 3 (slave 7) dest=2 -> host src 2 with toggling tready, 16 beats
        tog[2] = 1'b1;
        tx_len[7] = 16; tx_pos[7] = 0; tx_base[7] = 32'hD000; tx_route[7] = 14'h083C;
        run(200, 1'b1);
        tog[2] = 1'b0;
        chk("t5_count", 64'(rx_n[2]), 64'd16);
        for (int b = 0; b < 16; b++) begin
            chk("t5_data", 64'(rx_data[2][b]), 64'(32'hD000 + b));
        end
        chk("t5_last", 64'(rx_last[2][15]), 64'd1);
        chk("t5_no_early_last", 64'(rx_last[2][14]), 64'd0);

        // Reset mid-packet: host sink 0 -> DTU src 0 (master 4), 8 beats, cut short
        tx_len[0] = 8; tx_pos[0] = 0; tx_base[0] = 32'hE000;
        run(5, 1'b0);
        chk("t6_pre_valid", 64'(dm_tvalid[0]), 64'd1);
        chk("t6_pre_route0", 64'(route_out[0]), 64'h13FF);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_host_src_tvalid", 64'(hm_tvalid), 64'd0);
        chk("t6_dtu_src_tvalid",  64'(dm_tvalid), 64'd0);
        chk("t6_sink_tready", 64'({hs_tready, ds_tready}), 64'd0);
        chk("t6_route_out", 64'(route_out), 64'd0);
        chk("t6_err_cnt", 64'(decode_err_cnt), 64'd0);
        for (int s = 0; s < 8; s++) begin
            tx_len[s] = 0; tx_pos[s] = 0;
        end
        drive(0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        // Fresh packet: host sink 1 -> DTU src 1 (master 5), 2 beats
        tx_len[1] = 2; tx_pos[1] = 0; tx_base[1] = 32'hF000;
        run(40, 1'b1);
        chk("t6_fresh_count", 64'(rx_n[5]), 64'd2);
        chk("t6_fresh_data0", 64'(rx_data[5][0]), 64'h0000F000);
        chk("t6_fresh_data1", 64'(rx_data[5][1]), 64'h0000F001);
        chk("t6_fresh_last", 64'(rx_last[5][1]), 64'd1);
        chk("t6_fresh_route", 64'(route_out), {8'd0, 14'h0000, 14'h0000, 14'h17FF, 14'h0000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
